// File: rtl/ex_unit_pkg.sv
// Shared definitions for the multi-cycle execute stage: opcodes, FSM states
// and flag bit positions within the {Z,N,C,V} flag vector.
package ex_unit_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_PASSB = 4'd2;
    localparam logic [3:0] OP_MUL   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_NOTB  = 4'd7;
    localparam logic [3:0] OP_SHL   = 4'd8;
    localparam logic [3:0] OP_SHR   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_PASSA = 4'd11;
    localparam logic [3:0] OP_HOLD  = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

endpackage

// File: rtl/ex_iter_muldiv.sv
// Iterative engine shared by MUL (unsigned shift-add) and, when
// EX_UNIT_DIV_EN is defined, DIVU (unsigned restoring division).
// One bit per cycle; the first step is applied on the start cycle so the
// result is ready DATA_W-1 cycles after start. o_last flags the final step.
// MUL leaves the 2*DATA_W product in {o_hi,o_lo}; DIVU leaves the quotient
// in o_lo and the remainder in o_hi.
module ex_iter_muldiv
    import ex_unit_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
`ifdef EX_UNIT_DIV_EN
    input  logic              i_div,
`endif
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_last,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [DATA_W-1:0] r_hi, r_lo, r_opnd;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_run;

    logic [DATA_W-1:0] w_src_hi, w_src_lo, w_opnd;
    logic [DATA_W-1:0] w_nxt_hi, w_nxt_lo;
    logic [DATA_W:0]   w_sum;

    // On start the step works on the fresh operands instead of the registers
    assign w_src_hi = i_start ? '0 : r_hi;
`ifdef EX_UNIT_DIV_EN
    logic            r_div;
    logic            w_div;
    logic [DATA_W:0] w_tmp;
    logic            w_ge;

    assign w_div    = i_start ? i_div : r_div;
    assign w_src_lo = i_start ? (i_div ? i_a : i_b) : r_lo;
    assign w_opnd   = i_start ? (i_div ? i_b : i_a) : r_opnd;
    assign w_tmp    = {w_src_hi, w_src_lo[DATA_W-1]};
    assign w_ge     = (w_tmp >= {1'b0, w_opnd});
`else
    assign w_src_lo = i_start ? i_b : r_lo;
    assign w_opnd   = i_start ? i_a : r_opnd;
`endif

    assign w_sum = {1'b0, w_src_hi} + (w_src_lo[0] ? {1'b0, w_opnd} : '0);

    // One iteration: add-then-shift-right for MUL, shift-left-then-trial-subtract for DIVU
    always_comb begin
        w_nxt_hi = w_sum[DATA_W:1];
        w_nxt_lo = {w_sum[0], w_src_lo[DATA_W-1:1]};
`ifdef EX_UNIT_DIV_EN
        if (w_div) begin
            w_nxt_hi = w_ge ? (w_tmp[DATA_W-1:0] - w_opnd) : w_tmp[DATA_W-1:0];
            w_nxt_lo = {w_src_lo[DATA_W-2:0], w_ge};
        end
`endif
    end

    // Accumulator, operand and step counter; reset aborts any run
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_opnd <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
`ifdef EX_UNIT_DIV_EN
            r_div  <= 1'b0;
`endif
        end else if (i_start) begin
            r_hi   <= w_nxt_hi;
            r_lo   <= w_nxt_lo;
            r_opnd <= w_opnd;
            r_cnt  <= CNT_W'(1);
            r_run  <= 1'b1;
`ifdef EX_UNIT_DIV_EN
            r_div  <= i_div;
`endif
        end else if (r_run) begin
            r_hi  <= w_nxt_hi;
            r_lo  <= w_nxt_lo;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(DATA_W - 1))
                r_run <= 1'b0;
        end
    end

    assign o_last = r_run && (r_cnt == CNT_W'(DATA_W - 1));
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: rtl/ex_unit_mc.sv
// Multi-cycle execute stage with valid/ready on both sides.
// Single-cycle ALU ops load the output register at accept; MUL (and DIVU
// when EX_UNIT_DIV_EN is defined) run in ex_iter_muldiv and write back from
// the DONE state. busy covers the whole multi-cycle occupancy (MUL/DIV and
// the DONE write-back cycle), matching when in_ready is held low.
module ex_unit_mc
    import ex_unit_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] st_data,
    output logic [3:0]        flags,
    output logic              busy
);

    state_e            r_state;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_result, r_st_data, r_res_q, r_b_q;
    logic [3:0]        r_flags, r_flag_q;

    logic              w_accept, w_done, w_load, w_ld_upd;
    logic              w_start, w_upd, w_hold, w_zn_en;
    logic [DATA_W-1:0] w_alu_res, w_ld_res, w_ld_st;
    logic              w_alu_c, w_alu_v, w_eng_v, w_eng_last;
    logic [3:0]        w_alu_flg, w_ld_flg;
    logic [DATA_W-1:0] w_eng_hi, w_eng_lo;
    logic [SHAMT_W-1:0] w_sh;
    logic [DATA_W:0]   w_add, w_sub, w_shl, w_shr, w_sra;

    assign in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign busy     = (r_state != S_IDLE);
    assign w_done   = (r_state == S_DONE);

    // Carry/shift-out bits ride in the extra MSB (add/shl) or LSB (shr/sra)
    assign w_sh  = b[SHAMT_W-1:0];
    assign w_add = {1'b0, a} + {1'b0, b};
    assign w_sub = {1'b0, a} + {1'b0, ~b} + (DATA_W+1)'(1);
    assign w_shl = {1'b0, a} << w_sh;
    assign w_shr = {a, 1'b0} >> w_sh;
    assign w_sra = $signed({a, 1'b0}) >>> w_sh;

`ifdef EX_UNIT_DIV_EN
    logic w_div;
    logic r_is_div;
`endif

    // Single-cycle ALU result/flags and multi-cycle launch decode
    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        w_zn_en   = 1'b1;
        w_upd     = 1'b1;
        w_hold    = 1'b0;
        w_start   = 1'b0;
`ifdef EX_UNIT_DIV_EN
        w_div     = 1'b0;
`endif
        case (op)
            OP_ADD: begin
                w_alu_res = w_add[DATA_W-1:0];
                w_alu_c   = w_add[DATA_W];
                w_alu_v   = (a[DATA_W-1] == b[DATA_W-1]) && (w_add[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
                w_alu_res = w_sub[DATA_W-1:0];
                w_alu_c   = w_sub[DATA_W];
                w_alu_v   = (a[DATA_W-1] != b[DATA_W-1]) && (w_sub[DATA_W-1] != a[DATA_W-1]);
            end
            OP_PASSB: w_alu_res = b;
            OP_MUL:   w_start   = 1'b1;
            OP_AND:   w_alu_res = a & b;
            OP_OR:    w_alu_res = a | b;
            OP_XOR:   w_alu_res = a ^ b;
            OP_NOTB:  w_alu_res = ~b;
            OP_SHL: begin
                w_alu_res = w_shl[DATA_W-1:0];
                w_alu_c   = w_shl[DATA_W];
            end
            OP_SHR: begin
                w_alu_res = w_shr[DATA_W:1];
                w_alu_c   = w_shr[0];
            end
            OP_SRA: begin
                w_alu_res = w_sra[DATA_W:1];
                w_alu_c   = w_sra[0];
            end
            OP_PASSA: w_alu_res = a;
            OP_HOLD: begin
                w_alu_res = r_res_q;
                w_hold    = 1'b1;
                w_upd     = 1'b0;
            end
`ifdef EX_UNIT_DIV_EN
            OP_DIVU: begin
                // Divide by zero never enters the engine
                if (b == '0) begin
                    w_alu_res = '1;
                    w_alu_v   = 1'b1;
                end else begin
                    w_start = 1'b1;
                    w_div   = 1'b1;
                end
            end
`endif
            default: begin
                w_zn_en = 1'b0;
                w_upd   = 1'b0;
            end
        endcase
        w_alu_flg = w_hold ? r_flag_q
                           : {w_zn_en && (w_alu_res == '0), w_zn_en && w_alu_res[DATA_W-1],
                              w_alu_c, w_alu_v};
    end

    ex_iter_muldiv #(.DATA_W(DATA_W)) u_muldiv (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_accept && w_start),
`ifdef EX_UNIT_DIV_EN
        .i_div   (w_div),
`endif
        .i_a     (a),
        .i_b     (b),
        .o_last  (w_eng_last),
        .o_hi    (w_eng_hi),
        .o_lo    (w_eng_lo)
    );

`ifdef EX_UNIT_DIV_EN
    assign w_eng_v = r_is_div ? 1'b0 : (w_eng_hi != '0);
`else
    assign w_eng_v = (w_eng_hi != '0);
`endif

    // Output-register load source: engine in DONE, ALU on single-cycle accept
    assign w_load   = w_done || (w_accept && !w_start);
    assign w_ld_upd = w_done || w_upd;
    assign w_ld_res = w_done ? w_eng_lo : w_alu_res;
    assign w_ld_st  = w_done ? r_b_q : b;
    assign w_ld_flg = w_done ? {(w_eng_lo == '0), w_eng_lo[DATA_W-1], 1'b0, w_eng_v} : w_alu_flg;

    // Control FSM: IDLE -> MUL/DIV -> DONE -> IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept && w_start) begin
`ifdef EX_UNIT_DIV_EN
                    r_state <= w_div ? S_DIV : S_MUL;
`else
                    r_state <= S_MUL;
`endif
                end
                S_MUL, S_DIV: if (w_eng_last) r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Store data (and op kind) captured at accept for the multi-cycle write-back
    always_ff @(posedge clk) begin
        if (reset) begin
            r_b_q <= '0;
`ifdef EX_UNIT_DIV_EN
            r_is_div <= 1'b0;
`endif
        end else if (w_accept) begin
            r_b_q <= b;
`ifdef EX_UNIT_DIV_EN
            r_is_div <= w_div;
`endif
        end
    end

    // Output register: stable under backpressure, drops after consumption
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_st_data   <= '0;
            r_flags     <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_result    <= w_ld_res;
            r_st_data   <= w_ld_st;
            r_flags     <= w_ld_flg;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Architectural result/flags seen by HOLD; illegal ops and HOLD leave them alone
    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_q  <= '0;
            r_flag_q <= '0;
        end else if (w_load && w_ld_upd) begin
            r_res_q  <= w_ld_res;
            r_flag_q <= w_ld_flg;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign st_data   = r_st_data;
    assign flags     = r_flags;

endmodule
